arb2to1: RTL and testbench
==========================

# arb2to1

Two-input round-robin arbiter with a single-entry output register. It sits directly upstream of the 2:1 multiplexer and drives that mux's select line `s`. It accepts transfers from two valid/ready sources (`w0`, `w1`), picks one per cycle, and registers the chosen data together with its source index. It also keeps saturating per-source transfer counts for debug.

## Interface
- `WIDTH`, 1, data width of each source and of `out_data`
- `CNT_W`, 8, width of the per-source transfer counters
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `w0_valid`  in  1  source 0 has data
- `w0_data`  in  WIDTH  source 0 payload
- `w0_ready`  out  1  source 0 transfer accepted this cycle when high with `w0_valid`
- `w1_valid`  in  1  source 1 has data
- `w1_data`  in  WIDTH  source 1 payload
- `w1_ready`  out  1  source 1 transfer accepted this cycle when high with `w1_valid`
- `out_valid`  out  1  output register holds data
- `out_data`  out  WIDTH  registered payload
- `out_ready`  in  1  downstream consumes `out_data` this cycle when high with `out_valid`
- `s`  out  1  registered select; index of the source whose data is in `out_data` (0 = `w0`, 1 = `w1`)
- `cnt0`, `cnt1`  out  CNT_W  saturating counts of accepted transfers from `w0` and `w1`

## Operation
- Reset values:
  - `out_valid`=0, `out_data`=0, `s`=0, `cnt0`=`cnt1`=0.
  - Internal `last` pointer resets to 1, so `w0` wins the first contention.
- Two states, encoded by `out_valid`:
  - EMPTY (0)
  - FULL (1)
- `can_accept` = !`out_valid` | `out_ready`. Draining and refilling in the same cycle is allowed.
- Grant (combinational, only while `can_accept`=1):
  - Only `w0_valid` → grant 0.
  - Only `w1_valid` → grant 1.
  - Both valid → grant !`last`.
  - Neither valid → no grant.
- `w0_ready` = `can_accept` & grant==0 & `w0_valid`. `w1_ready` is the mirror.
- The `ready` of a losing or non-requesting source is 0. Both readies are never high together.
- On accept (a grant exists):
  - `out_data` ← granted `wX_data`; `s` ← grant; `last` ← grant; `out_valid` ← 1.
  - The count of the granted source increments, but holds at 2^CNT_W−1 once saturated.
- Drain with no accept (`out_valid` & `out_ready` & no grant): `out_valid` ← 0. `out_data` and `s` hold their last values.
- FULL & !`out_ready`:
  - All registers hold.
  - Both readies are 0.
  - `last` does not move.
- `last` updates only on an actual accept. Uncontended grants also update `last`.
- Sources may drop `valid` at any time. The arbiter holds no per-source lock.

## Timing
- Accept in cycle N → `out_valid`=1, `out_data`, `s` valid after edge N+1 (1-cycle latency).
- Sustained throughput is 1 transfer/cycle while `out_ready`=1.
- Under continuous contention, grants alternate 0,1,0,1,… (first grant after reset = 0).
- `s` changes only on an accept edge. It is stable for the whole time a given `out_data` is presented.
- Readies are combinational from the `valid` inputs, `out_ready` and registered state. There is no combinational path from any `wX_data` to any output.
- Reset:
  - Assertion of `rst_n` (low) mid-transfer immediately clears `out_valid`, the counters and `s`, and sets `last`=1, independent of `clk`.
  - Readies follow combinationally. With `out_valid`=0 a source may be granted, but no state updates while `rst_n` is low.
  - First accept is possible on the first rising edge after deassertion.

## Test plan
- Reset:
  - Assert `rst_n`=0 mid-stream with `out_valid`=1 → `out_valid`, `s`, `cnt0`, `cnt1` go to 0 without a clock edge.
  - After release, both sources valid → first grant `w0`.
- Single source, `WIDTH`=1, `out_ready`=1, `w1_valid`=1 with data 1,0,1 on three cycles:
  - `w1_ready`=1 every cycle.
  - `out_data` = 1,0,1 one cycle later, `s`=1 throughout.
  - `cnt1`=3, `cnt0`=0.
- Contention, both valid for 6 cycles with `out_ready`=1 → `s` sequence 0,1,0,1,0,1; `cnt0`=`cnt1`=3.
- Backpressure:
  - Fill, then hold `out_ready`=0 for 4 cycles with both valid → both readies 0, `out_data`/`s` unchanged.
  - Raise `out_ready` → drain and refill in the same cycle, next grant is the opposite of the held `s`.
- Empty drain: one `w0` transfer, then no valid with `out_ready`=1 → `out_valid` falls after one cycle, `s` stays 0.
- Saturation with `CNT_W`=2: 5 `w0` transfers → `cnt0`=3 after the third and stays 3.

Source files
------------

// File: rtl/arb2to1_if.sv
// Source/sink bundle for the 2:1 round-robin arbiter: two valid/ready inputs,
// one registered output with its select, and the debug transfer counts.
interface arb2to1_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic             w0_valid;
    logic [WIDTH-1:0] w0_data;
    logic             w0_ready;
    logic             w1_valid;
    logic [WIDTH-1:0] w1_data;
    logic             w1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             s;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    // Environment side: drives the sources and the downstream ready.
    modport master (
        output w0_valid, w0_data, w1_valid, w1_data, out_ready,
        input  w0_ready, w1_ready, out_valid, out_data, s, cnt0, cnt1
    );

    // Arbiter side.
    modport slave (
        input  w0_valid, w0_data, w1_valid, w1_data, out_ready,
        output w0_ready, w1_ready, out_valid, out_data, s, cnt0, cnt1
    );
endinterface

// File: rtl/arb2to1.sv
// Two-input round-robin arbiter with a single-entry output register that also
// drives the downstream mux select, plus saturating per-source transfer counts.
module arb2to1_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = (inc_i && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module arb2to1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    arb2to1_if.slave   bus
);
    localparam int NUM_SRC = 2;

    // The output register's occupancy is the state itself.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e                         state_q, state_d;
    logic [WIDTH-1:0]               data_q, data_d;
    logic                           s_q, s_d;
    logic                           last_q, last_d;

    logic [NUM_SRC-1:0]             src_valid;
    logic [NUM_SRC-1:0]             src_ready;
    logic [NUM_SRC-1:0][WIDTH-1:0]  src_data;
    logic [NUM_SRC-1:0][CNT_W-1:0]  cnt;

    logic                           can_accept;
    logic                           gnt_vld;
    logic                           gnt_idx;

    assign src_valid = {bus.w1_valid, bus.w0_valid};
    assign src_data  = {bus.w1_data,  bus.w0_data};

    assign can_accept = (state_q == EMPTY) || bus.out_ready;

    // Round-robin: on contention the source not granted last time wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (can_accept) begin
            case (src_valid)
                2'b01:   begin gnt_vld = 1'b1; gnt_idx = 1'b0;    end
                2'b10:   begin gnt_vld = 1'b1; gnt_idx = 1'b1;    end
                2'b11:   begin gnt_vld = 1'b1; gnt_idx = ~last_q; end
                default: begin gnt_vld = 1'b0; gnt_idx = 1'b0;    end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_ready[i] = gnt_vld && (gnt_idx == 1'(i)) && src_valid[i];

        arb2to1_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (src_ready[i]),
            .cnt_o (cnt[i])
        );
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        s_d     = s_q;
        last_d  = last_q;
        case (state_q)
            EMPTY: begin
                if (gnt_vld) state_d = FULL;
            end
            FULL: begin
                // A drain with nothing to refill empties; data and select hold.
                if (bus.out_ready && !gnt_vld) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        if (gnt_vld) begin
            data_d = src_data[gnt_idx];
            s_d    = gnt_idx;
            last_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            s_q     <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            s_q     <= s_d;
            last_q  <= last_d;
        end
    end

    assign bus.w0_ready  = src_ready[0];
    assign bus.w1_ready  = src_ready[1];
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.s         = s_q;
    assign bus.cnt0      = cnt[0];
    assign bus.cnt1      = cnt[1];
endmodule

// File: tb/tb_arb2to1.sv
// Self-checking bench for arb2to1: directed vector table, async-reset and
// saturation sequences, then randomized traffic against a behavioural model.
module tb_arb2to1;
    localparam int WIDTH = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    arb2to1_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    arb2to1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic             w0v;
        logic [WIDTH-1:0] w0d;
        logic             w1v;
        logic [WIDTH-1:0] w1d;
        logic             ordy;
        logic             r0;
        logic             r1;
        logic             ov;
        logic [WIDTH-1:0] od;
        logic             s;
        int               c0;
        int               c1;
    } vec_t;

    vec_t tbl[$];

    task automatic drive(input logic w0v, input logic [WIDTH-1:0] w0d,
                         input logic w1v, input logic [WIDTH-1:0] w1d,
                         input logic ordy);
        bus.w0_valid  = w0v;
        bus.w0_data   = w0d;
        bus.w1_valid  = w1v;
        bus.w1_data   = w1d;
        bus.out_ready = ordy;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Reference model state
    logic       m_ov, m_s, m_last;
    logic [WIDTH-1:0] m_od;
    int         m_c[2];

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);

        //            w0v w0d w1v w1d  rdy  r0 r1  ov od  s   c0 c1
        // single source w1 with data 1,0,1
        tbl.push_back('{0, 0, 1, 1,  1,  0, 1,  1, 1,  1,  0, 1});
        tbl.push_back('{0, 0, 1, 0,  1,  0, 1,  1, 0,  1,  0, 2});
        tbl.push_back('{0, 0, 1, 1,  1,  0, 1,  1, 1,  1,  0, 3});
        // contention: alternate starting with w0 (last grant was w1)
        tbl.push_back('{1, 5, 1, 10, 1,  1, 0,  1, 5,  0,  1, 3});
        tbl.push_back('{1, 5, 1, 10, 1,  0, 1,  1, 10, 1,  1, 3});
        tbl.push_back('{1, 5, 1, 10, 1,  1, 0,  1, 5,  0,  2, 3});
        tbl.push_back('{1, 5, 1, 10, 1,  0, 1,  1, 10, 1,  2, 3});
        tbl.push_back('{1, 5, 1, 10, 1,  1, 0,  1, 5,  0,  3, 3});
        tbl.push_back('{1, 5, 1, 10, 1,  0, 1,  1, 10, 1,  3, 3});
        // backpressure for 4 cycles
        for (int i = 0; i < 4; i++)
            tbl.push_back('{1, 3, 1, 12, 0,  0, 0,  1, 10, 1,  3, 3});
        // release: drain + refill, grant opposite of held s
        tbl.push_back('{1, 3, 1, 12, 1,  1, 0,  1, 3,  0,  3, 3});
        // single w0 transfer then empty drain
        tbl.push_back('{1, 7, 0, 0,  1,  1, 0,  1, 7,  0,  3, 3});
        tbl.push_back('{0, 0, 0, 0,  1,  0, 0,  0, 7,  0,  3, 3});
        tbl.push_back('{0, 0, 0, 0,  0,  0, 0,  0, 7,  0,  3, 3});
        // empty accepts even with out_ready low, then holds
        tbl.push_back('{0, 0, 1, 9,  0,  0, 1,  1, 9,  1,  3, 3});
        tbl.push_back('{1, 4, 0, 0,  0,  0, 0,  1, 9,  1,  3, 3});

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_s",         bus.s,         0);
        chk("rst_cnt0",      bus.cnt0,      0);
        chk("rst_cnt1",      bus.cnt1,      0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table
        foreach (tbl[k]) begin
            if (k != 0) @(negedge clk);
            drive(tbl[k].w0v, tbl[k].w0d, tbl[k].w1v, tbl[k].w1d, tbl[k].ordy);
            #1;
            chk($sformatf("vec%0d_w0_ready", k), bus.w0_ready, tbl[k].r0);
            chk($sformatf("vec%0d_w1_ready", k), bus.w1_ready, tbl[k].r1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", k), bus.out_valid, tbl[k].ov);
            if (tbl[k].ov)
                chk($sformatf("vec%0d_out_data", k), bus.out_data, tbl[k].od);
            chk($sformatf("vec%0d_s", k),    bus.s,    tbl[k].s);
            chk($sformatf("vec%0d_cnt0", k), bus.cnt0, tbl[k].c0);
            chk($sformatf("vec%0d_cnt1", k), bus.cnt1, tbl[k].c1);
        end

        // async reset mid-stream: out_valid=1, s=1, counters saturated
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", bus.out_valid, 0);
        chk("async_s",         bus.s,         0);
        chk("async_cnt0",      bus.cnt0,      0);
        chk("async_cnt1",      bus.cnt1,      0);
        drive(1, 6, 1, 11, 1);
        #1;
        chk("inrst_w0_ready", bus.w0_ready, 1);
        chk("inrst_w1_ready", bus.w1_ready, 0);
        @(posedge clk);
        #1;
        chk("inrst_no_update", bus.out_valid, 0);
        chk("inrst_cnt0",      bus.cnt0,      0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_grant_valid", bus.out_valid, 1);
        chk("first_grant_s",     bus.s,         0);
        chk("first_grant_data",  bus.out_data,  6);

        // counter saturation: 5 w0 transfers
        rst_pulse();
        for (int k = 1; k <= 5; k++) begin
            if (k != 1) @(negedge clk);
            drive(1, 4'(k), 0, 0, 1);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d_cnt0", k), bus.cnt0, (k > CMAX) ? CMAX : k);
            chk($sformatf("sat%0d_cnt1", k), bus.cnt1, 0);
        end

        // randomized traffic vs. behavioural model
        rst_pulse();
        m_ov = 0; m_s = 0; m_last = 1; m_od = '0; m_c[0] = 0; m_c[1] = 0;
        for (int k = 0; k < 400; k++) begin
            logic v0, v1, rdy, gv, g;
            logic [WIDTH-1:0] d0, d1;
            if (k != 0) @(negedge clk);
            v0  = ($urandom_range(0, 99) < 65);
            v1  = ($urandom_range(0, 99) < 65);
            rdy = ($urandom_range(0, 99) < 70);
            d0  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            d1  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            drive(v0, d0, v1, d1, rdy);
            gv = 0; g = 0;
            if (!m_ov || rdy) begin
                if (v0 && v1)  begin gv = 1; g = !m_last; end
                else if (v0)   begin gv = 1; g = 0; end
                else if (v1)   begin gv = 1; g = 1; end
            end
            #1;
            chk($sformatf("rnd%0d_w0_ready", k), bus.w0_ready, int'(gv && !g));
            chk($sformatf("rnd%0d_w1_ready", k), bus.w1_ready, int'(gv && g));
            if (gv) begin
                m_od = g ? d1 : d0;
                m_s = g; m_last = g; m_ov = 1;
                if (m_c[g] < CMAX) m_c[g]++;
            end else if (m_ov && rdy) begin
                m_ov = 0;
            end
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_out_valid", k), bus.out_valid, m_ov);
            chk($sformatf("rnd%0d_out_data", k),  bus.out_data,  m_od);
            chk($sformatf("rnd%0d_s", k),         bus.s,         m_s);
            chk($sformatf("rnd%0d_cnt0", k),      bus.cnt0,      m_c[0]);
            chk($sformatf("rnd%0d_cnt1", k),      bus.cnt1,      m_c[1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
